// File: rtl/vedic_mult_seq.sv
// Sequential Urdhva-Tiryagbhyam multiplier: one 4x4 digit product per clock into a shifted accumulator.
// Optional two's-complement support is compiled in with VEDIC_MULT_SIGNED_EN.
module vedic_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned NN = N * N;
    localparam int unsigned KW = (NN > 1) ? $clog2(NN) : 1;
    localparam int unsigned SW = $clog2(PW) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [KW-1:0]     k_q, k_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
`ifdef VEDIC_MULT_SIGNED_EN
    logic              neg_q, neg_d;
    logic              neg_in;
`else
    logic              unused_signed_mode;
`endif

    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [KW-1:0]     di, dj;
    logic [3:0]        ad, bd;
    logic [7:0]        pp;
    logic [SW-1:0]     shamt;
    logic [PW-1:0]     acc_next, prod_next;

    // Operand magnitudes and result sign captured at acceptance
`ifdef VEDIC_MULT_SIGNED_EN
    always_comb begin
        neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        a_mag  = (signed_mode & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag  = (signed_mode & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end
`else
    assign unused_signed_mode = signed_mode;
    assign a_mag = a;
    assign b_mag = b;
`endif

    // Digit-pair product for step k, shifted by the combined digit weight
    always_comb begin
        di        = KW'(k_q / KW'(N));
        dj        = KW'(k_q % KW'(N));
        ad        = a_q[4*di +: 4];
        bd        = b_q[4*dj +: 4];
        pp        = {4'b0000, ad} * {4'b0000, bd};
        shamt     = SW'(4) * (SW'(di) + SW'(dj));
        acc_next  = acc_q + (PW'(pp) << shamt);
`ifdef VEDIC_MULT_SIGNED_EN
        prod_next = neg_q ? (~acc_next + PW'(1)) : acc_next;
`else
        prod_next = acc_next;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        k_d         = k_q;
        prod_d      = prod_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef VEDIC_MULT_SIGNED_EN
        neg_d       = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d        = a_mag;
                    b_d        = b_mag;
`ifdef VEDIC_MULT_SIGNED_EN
                    neg_d      = neg_in;
`endif
                    acc_d      = '0;
                    k_d        = '0;
                    state_d    = S_MUL;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_MUL: begin
                acc_d = acc_next;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(NN - 1)) begin
                    prod_d      = prod_next;
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef VEDIC_MULT_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            prod_q      <= prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef VEDIC_MULT_SIGNED_EN
            neg_q       <= neg_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = prod_q;

endmodule
